// File: rtl/instr_prefetch_buffer_if.sv
// Instruction-bus bundle between the prefetch buffer and instruction memory.
// Carries the req/gnt address phase and the in-order rvalid response phase.
// master: prefetch buffer (drives req/addr); slave: memory (drives gnt/rdata/err/rvalid).
interface instr_prefetch_buffer_if;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        instr_rvalid_i;

  modport master (
    output instr_req_o,
    output instr_addr_o,
    input  instr_gnt_i,
    input  instr_rdata_i,
    input  instr_err_i,
    input  instr_rvalid_i
  );

  modport slave (
    input  instr_req_o,
    input  instr_addr_o,
    output instr_gnt_i,
    output instr_rdata_i,
    output instr_err_i,
    output instr_rvalid_i
  );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// Purpose: prefetches instruction words over a req/gnt/rvalid bus into an in-order FIFO popped by fetch.
// Latency: bus rvalid in cycle t -> valid_o in cycle t+1 (same cycle with PREFETCH_BYPASS_EN on an empty FIFO).
// Backpressure: new requests only while outstanding < NUM_REQS and FIFO entries + outstanding < DEPTH.
// Ports: clk/rst (sync, active-high); req_i fetch enable; branch_i/branch_addr_i redirect;
//        valid_o/ready_i/rdata_o/addr_o/err_o FIFO head; busy_o requests in flight; bus = instruction bus master.
// Optional macro PREFETCH_BYPASS_EN: empty-FIFO responses are forwarded combinationally to the outputs.
module instr_prefetch_buffer #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          NUM_REQS = 2,
  parameter int          DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  input  logic                      branch_i,
  input  logic [31:0]               branch_addr_i,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic [31:0]               rdata_o,
  output logic [31:0]               addr_o,
  output logic                      err_o,
  output logic                      busy_o,
  instr_prefetch_buffer_if.master   bus
);

  localparam int OW = $clog2(NUM_REQS + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  logic [31:2]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   resp_addr_q, resp_addr_d;   // bit 1 kept so the first word after a branch is halfword-tagged
  logic [31:2]   pend_addr_q, pend_addr_d;
  logic          pend_branch_q, pend_branch_d;
  logic          held_q, held_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic          issue_ok, gnt, rsp_vld, rsp_keep, push, pop, fifo_empty;
  logic          byp_vld, byp_take;
  logic [OW-1:0] disc_tmp;
  entry_t        rsp_entry, head;

  always_comb begin
    fifo_empty = (count_q == '0);
    // Responses arriving with nothing outstanding are strays and are ignored.
    rsp_vld    = bus.instr_rvalid_i & (outstanding_q != '0);
    rsp_keep   = rsp_vld & (discard_q == '0) & ~branch_i;
    rsp_entry  = '{rdata: bus.instr_rdata_i, addr: resp_addr_q, err: bus.instr_err_i};
    head       = mem_q[rd_ptr_q];

    // No fresh issue on a redirect cycle: the target address is only loaded at the edge.
    issue_ok = req_i & ~rst & ~branch_i
             & (32'(outstanding_q) < 32'(NUM_REQS))
             & ((32'(count_q) + 32'(outstanding_q)) < 32'(DEPTH));
    bus.instr_req_o  = held_q | issue_ok;
    bus.instr_addr_o = {fetch_addr_q, 2'b00};
    gnt              = bus.instr_req_o & bus.instr_gnt_i;

`ifdef PREFETCH_BYPASS_EN
    byp_vld  = fifo_empty & rsp_keep;
    byp_take = byp_vld & ready_i;
`else
    byp_vld  = 1'b0;
    byp_take = 1'b0;
`endif
    push = rsp_keep & ~byp_take;
    pop  = ~fifo_empty & ready_i & ~branch_i;

    if (byp_vld) begin
      valid_o = 1'b1;
      rdata_o = rsp_entry.rdata;
      addr_o  = rsp_entry.addr;
      err_o   = rsp_entry.err;
    end else begin
      valid_o = ~fifo_empty;
      rdata_o = head.rdata;
      addr_o  = head.addr;
      err_o   = head.err;
    end
    busy_o = (outstanding_q != '0);
  end

  // Request / address bookkeeping
  always_comb begin
    held_d        = bus.instr_req_o & ~bus.instr_gnt_i;
    fetch_addr_d  = fetch_addr_q;
    resp_addr_d   = resp_addr_q;
    pend_addr_d   = pend_addr_q;
    pend_branch_d = pend_branch_q;

    case ({gnt, rsp_vld})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    disc_tmp = discard_q;
    if (rsp_vld && (discard_q != '0)) disc_tmp = discard_q - OW'(1);
    discard_d = disc_tmp;

    if (rsp_keep) resp_addr_d = {resp_addr_q[31:2] + 30'd1, 2'b00};

    if (branch_i) begin
      // Everything in flight after this cycle is stale, including a request granted right now.
      discard_d   = outstanding_d;
      resp_addr_d = branch_addr_i;
      if (held_q && !bus.instr_gnt_i) begin
        // Held address must stay stable; retarget once it is granted.
        pend_branch_d = 1'b1;
        pend_addr_d   = branch_addr_i[31:2];
      end else begin
        pend_branch_d = 1'b0;
        fetch_addr_d  = branch_addr_i[31:2];
      end
    end else if (gnt) begin
      if (pend_branch_q) begin
        discard_d     = disc_tmp + OW'(1);
        fetch_addr_d  = pend_addr_q;
        pend_branch_d = 1'b0;
      end else begin
        fetch_addr_d  = fetch_addr_q + 30'd1;
      end
    end
  end

  // FIFO
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (branch_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = rsp_entry;
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr_q  <= PC_RESET[31:2];
      resp_addr_q   <= {PC_RESET[31:2], 2'b00};
      pend_addr_q   <= '0;
      pend_branch_q <= 1'b0;
      held_q        <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      mem_q         <= '{default: '0};
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      resp_addr_q   <= resp_addr_d;
      pend_addr_q   <= pend_addr_d;
      pend_branch_q <= pend_branch_d;
      held_q        <= held_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      mem_q         <= mem_d;
    end
  end

  // The credit check on issue makes a push into a full FIFO without a pop impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == CW'(DEPTH)) && !pop));

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
module tb_instr_prefetch_buffer;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
  } word_t;

  logic        clk = 1'b0;
  logic        rst, req_i, branch_i, ready_i;
  logic [31:0] branch_addr_i;
  logic        valid_o, err_o, busy_o;
  logic [31:0] rdata_o, addr_o;

  instr_prefetch_buffer_if bus ();

  instr_prefetch_buffer #(
    .PC_RESET (32'h0000_0100),
    .NUM_REQS (2),
    .DEPTH    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .rdata_o       (rdata_o),
    .addr_o        (addr_o),
    .err_o         (err_o),
    .busy_o        (busy_o),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] glog[$];   // every granted bus address
  logic [31:0] gq[$];     // granted, not yet answered
  word_t       plog[$];   // every word popped by the consumer
  int          mout = 0;
  int          max_out = 0;
  bit          auto_rsp = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory returns {16'hDEAD, word address[15:0]}.
  task automatic tick();
    logic [31:0] a;
    word_t       w;
    #1;
    if (!rst && bus.instr_req_o && bus.instr_gnt_i) begin
      gq.push_back(bus.instr_addr_o);
      glog.push_back(bus.instr_addr_o);
      mout++;
    end
    if (!rst && bus.instr_rvalid_i && mout > 0) mout--;
    if (mout > max_out) max_out = mout;
    if (!rst && valid_o && ready_i && !branch_i) begin
      w.a = addr_o; w.d = rdata_o; w.e = err_o;
      plog.push_back(w);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mout = 0;
      gq.delete();
    end
    if (auto_rsp && gq.size() > 0) begin
      a = gq.pop_front();
      bus.instr_rvalid_i = 1'b1;
      bus.instr_rdata_i  = {16'hDEAD, a[15:0]};
      bus.instr_err_i    = (a == err_addr);
    end else begin
      bus.instr_rvalid_i = 1'b0;
      bus.instr_rdata_i  = 32'h0;
      bus.instr_err_i    = 1'b0;
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    branch_addr_i = tgt;
    branch_i = 1'b1;
    tick();
    branch_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_i = 1'b0; branch_i = 1'b0; ready_i = 1'b0; branch_addr_i = 32'h0;
    bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0;
    bus.instr_rdata_i = 32'h0; bus.instr_err_i = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_req",   {31'b0, bus.instr_req_o}, 32'h0);
    chk("rst_busy",  {31'b0, busy_o}, 32'h0);
    chk("rst_err",   {31'b0, err_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    rst = 1'b0;
    #1;
    chk("idle_req",  {31'b0, bus.instr_req_o}, 32'h0);
    chk("rst_addr",  bus.instr_addr_o, 32'h100);

    // Streaming from PC_RESET with an error on 0x108
    err_addr = 32'h108; glog.delete(); plog.delete();
    req_i = 1'b1; bus.instr_gnt_i = 1'b1; auto_rsp = 1'b1; ready_i = 1'b1;
    repeat (8) tick();
    req_i = 1'b0;
    repeat (4) tick();
    chk("s_g0",     glog[0], 32'h100);
    chk("s_g1",     glog[1], 32'h104);
    chk("s_g2",     glog[2], 32'h108);
    chk("s_g3",     glog[3], 32'h10C);
    chk("s_p0a",    plog[0].a, 32'h100);
    chk("s_p0d",    plog[0].d, 32'hDEAD0100);
    chk("s_p1a",    plog[1].a, 32'h104);
    chk("s_p1e",    {31'b0, plog[1].e}, 32'h0);
    chk("s_p2e",    {31'b0, plog[2].e}, 32'h1);
    chk("s_p3a",    plog[3].a, 32'h10C);
    chk("s_p3e",    {31'b0, plog[3].e}, 32'h0);
    chk("s_npop",   plog.size(), 32'd8);
    chk("s_busy",   {31'b0, busy_o}, 32'h0);
    err_addr = 32'hFFFF_FFFF;

    // Backpressure: DEPTH words buffered, one pop frees one request
    redirect(32'h600);
    glog.delete(); plog.delete();
    ready_i = 1'b0; req_i = 1'b1;
    repeat (10) tick();
    chk("bp_ngnt",  glog.size(), 32'd4);
    chk("bp_req",   {31'b0, bus.instr_req_o}, 32'h0);
    chk("bp_head",  addr_o, 32'h600);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    repeat (4) tick();
    chk("bp_ngnt2", glog.size(), 32'd5);
    chk("bp_g4",    glog[4], 32'h610);
    chk("bp_head2", addr_o, 32'h604);
    chk("bp_req2",  {31'b0, bus.instr_req_o}, 32'h0);
    req_i = 1'b0; ready_i = 1'b1;
    repeat (8) tick();
    chk("bp_npop",  plog.size(), 32'd5);
    chk("bp_p4a",   plog[4].a, 32'h610);

    // Redirect with two requests outstanding; same-cycle response is dropped
    redirect(32'h200);
    auto_rsp = 1'b0; req_i = 1'b1;
    tick(); tick();
    chk("br_busy",  {31'b0, busy_o}, 32'h1);
    chk("br_limit", {31'b0, bus.instr_req_o}, 32'h0);
    glog.delete(); plog.delete();
    req_i = 1'b0; auto_rsp = 1'b1;
    bus.instr_rvalid_i = 1'b1;
    bus.instr_rdata_i  = {16'hDEAD, gq[0][15:0]};
    void'(gq.pop_front());
    redirect(32'h402);
    req_i = 1'b1;
    #1;
    chk("br_addr",  bus.instr_addr_o, 32'h400);
    tick(); tick();
    req_i = 1'b0;
    repeat (5) tick();
    chk("br_g0",    glog[0], 32'h400);
    chk("br_p0a",   plog[0].a, 32'h402);
    chk("br_p0d",   plog[0].d, 32'hDEAD0400);
    chk("br_p1a",   plog[1].a, 32'h404);
    chk("br_npop",  plog.size(), 32'd2);

    // Redirects while a request is held ungranted; the later target wins
    redirect(32'h300);
    glog.delete(); plog.delete();
    bus.instr_gnt_i = 1'b0; req_i = 1'b1;
    tick();
    req_i = 1'b0;
    branch_addr_i = 32'h580; branch_i = 1'b1;
    #1;
    chk("h_req",    {31'b0, bus.instr_req_o}, 32'h1);
    chk("h_addr",   bus.instr_addr_o, 32'h300);
    tick();
    branch_addr_i = 32'h500;
    tick();
    branch_i = 1'b0;
    #1;
    chk("h_addr2",  bus.instr_addr_o, 32'h300);
    bus.instr_gnt_i = 1'b1; req_i = 1'b1;
    tick(); tick(); tick();
    req_i = 1'b0;
    repeat (5) tick();
    chk("h_g0",     glog[0], 32'h300);
    chk("h_g1",     glog[1], 32'h500);
    chk("h_p0a",    plog[0].a, 32'h500);
    chk("h_p0d",    plog[0].d, 32'hDEAD0500);

    // Synchronous reset with two outstanding, then a stray response
    redirect(32'h200);
    auto_rsp = 1'b0; req_i = 1'b1;
    tick(); tick();
    chk("r_busy",   {31'b0, busy_o}, 32'h1);
    req_i = 1'b0; rst = 1'b1;
    tick();
    chk("r_busy0",  {31'b0, busy_o}, 32'h0);
    rst = 1'b0;
    bus.instr_rvalid_i = 1'b1; bus.instr_rdata_i = 32'h1234_5678;
    tick();
    chk("r_stray",  {31'b0, valid_o}, 32'h0);
    chk("r_busy1",  {31'b0, busy_o}, 32'h0);
    req_i = 1'b1;
    #1;
    chk("r_req",    {31'b0, bus.instr_req_o}, 32'h1);
    chk("r_addr",   bus.instr_addr_o, 32'h100);
    req_i = 1'b0;
    tick(); tick();

    chk("max_out",  {31'b0, (max_out <= 2)}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
